act_stream: RTL
===============

# act_stream

Streaming, pipelined activation unit for the CNN datapath. It accepts `LANES` signed fixed-point elements per beat over a valid/ready handshake and applies a runtime-selected activation: pass-through, ReLU, leaky ReLU or clamped ReLU. It tracks frame boundaries with a beat counter and marks the last beat of each frame. It sits between convolution/accumulator output and the next layer's input buffer, and replaces whole-tensor combinational activation with a frame-streamed, backpressure-aware block.

## Interface
- `BIT_REP`, 8, element width in bits, signed two's complement
- `LANES`, 4, elements per beat (channels processed in parallel)
- `FRAME_BEATS`, 64, beats per frame (width × length × depth / LANES); must be ≥ 2
- `LEAK_SHIFT`, 3, arithmetic right-shift applied to negative values in leaky mode

- `clk`  in  1  clock; all logic is rising-edge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  activation: 0 = pass, 1 = ReLU, 2 = leaky, 3 = clamp
- `clamp_max`  in  BIT_REP  signed upper bound for clamp mode
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `in_data`  in  LANES×BIT_REP  packed; lane i is at `[i*BIT_REP +: BIT_REP]`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  LANES×BIT_REP  activated lanes, same packing as the input
- `out_last`  out  1  high with the final beat of a frame
- `stat_zero`  out  $clog2(FRAME_BEATS*LANES+1)  zero-lane count of the last completed frame
- `stat_valid`  out  1  one-cycle pulse when `stat_zero` updates

## Operation
- Two-stage pipeline:
  - S1 registers the input lanes, the frame-last flag and the frame's mode/clamp.
  - S2 registers the activated result.
- Global stall: `stall = out_valid & ~out_ready`, and `in_ready = ~stall`.
  - On stall, S1 and S2 hold.
  - Otherwise both stages advance; bubbles propagate as valid = 0.
- Per lane, with x the signed lane value:
  - pass: y = x.
  - ReLU: y = (x > 0) ? x : 0.
  - leaky: y = (x ≥ 0) ? x : (x >>> LEAK_SHIFT). The shift floors, so −1 → −1 and −8 → −1 with LEAK_SHIFT = 3.
  - clamp: y = min(max(x, 0), clamp_max). If clamp_max ≤ 0, y = 0.
  - The output width always equals BIT_REP, so no overflow is possible.
- Frame beat counter: 0..FRAME_BEATS−1. It increments on each input handshake (`in_valid & in_ready`) and wraps to 0 after FRAME_BEATS−1.
- Mode latching:
  - `mode` and `clamp_max` are captured on the handshake of beat 0 of each frame.
  - Changes mid-frame are ignored until the next frame's beat 0.
  - Beat 0 itself uses the live values.
- `out_last` travels with the beat that was accepted at counter = FRAME_BEATS−1.

## Timing
- Latency: a beat accepted in cycle N appears on `out_valid`/`out_data` in cycle N+2 when there is no stall.
- Throughput: one beat per cycle while `out_ready` = 1.
- Output hold: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_last` hold stable and `in_ready` = 0 in the same cycle.
- `in_ready` depends combinationally on `out_ready`; this is the only combinational input-to-output path.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_last` = 0, `stat_zero` = 0, `stat_valid` = 0, beat counter = 0, latched mode = 0, latched clamp = 0.
  - `in_ready` = 1 in the cycle after reset.
- Reset mid-frame:
  - In-flight beats are dropped, with no output.
  - The counter returns to 0, so the next accepted beat is beat 0 of a new frame.
  - Stats accumulation restarts.
- `in_valid` with X data while `in_ready` = 0 has no effect.

## Configuration
- `ACT_STATS_EN` defined:
  - A zero-lane accumulator counts output lanes equal to 0 on each output handshake.
  - On the handshake of the `out_last` beat, `stat_zero` loads the frame total (including that beat) and `stat_valid` pulses for one cycle.
  - The accumulator then clears. The counter cannot overflow by construction.
- `ACT_STATS_EN` undefined:
  - The accumulator logic is not compiled.
  - `stat_zero` = 0 and `stat_valid` = 0 constantly.
  - All ports remain present.

## Test plan
- **ReLU**, LANES = 4, mode = 1, one beat {−5, 0, 7, −128}, `out_ready` = 1 → {0, 0, 7, 0} at acceptance + 2 cycles, `out_valid` high for 1 cycle.
- **Leaky and clamp**:
  - mode = 2 on {−8, −1, 16, −128} → {−1, −1, 16, −16}.
  - Next frame, mode = 3, clamp_max = 6, on {−3, 3, 6, 100} → {0, 3, 6, 6}.
  - clamp_max = −4 → all lanes 0.
- **Backpressure**: stream 10 beats while toggling `out_ready` 1,0,0,1,… → exact in-order data, no loss or duplication; `in_ready` low exactly in cycles where `out_valid` & ~`out_ready`.
- **Framing and mode latch**, FRAME_BEATS = 4:
  - Send 8 beats, switching mode from 1 to 0 at beat 2 → beats 0–3 are ReLU, beats 4–7 are pass.
  - `out_last` is high on output beats 3 and 7 only.
- **Reset mid-frame**: assert `rst` after 2 of 4 beats with 2 beats in flight → no outputs after reset; the next 4 beats form a frame with `out_last` on the 4th.
- **Stats (ACT_STATS_EN)**:
  - A ReLU frame of 4 beats containing 5 non-positive lanes → `stat_zero` = 5 and a `stat_valid` pulse on the cycle after the `out_last` handshake.
  - Without the macro → both outputs stay 0.

Source files
------------

// File: rtl/act_stream_if.sv
// Stream bundle for act_stream: input beats, activated output beats, runtime
// activation controls and the per-frame zero-lane statistic.
interface act_stream_if #(
    parameter int BIT_REP     = 8,
    parameter int LANES       = 4,
    parameter int FRAME_BEATS = 64
);
    localparam int DATA_W = LANES * BIT_REP;
    localparam int STAT_W = $clog2(FRAME_BEATS * LANES + 1);

    logic [1:0]         mode;
    logic [BIT_REP-1:0] clamp_max;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_last;
    logic [STAT_W-1:0]  stat_zero;
    logic               stat_valid;

    // Upstream producer / downstream consumer side.
    modport master (
        output mode, clamp_max, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, stat_zero, stat_valid
    );

    // Activation unit side.
    modport slave (
        input  mode, clamp_max, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, stat_zero, stat_valid
    );
endinterface

// File: rtl/act_stream.sv
// Two-stage streaming activation unit (pass/ReLU/leaky/clamp) with frame tracking.
// Optional zero-lane frame statistics are compiled in when ACT_STATS_EN is defined.
module act_stream #(
    parameter int BIT_REP     = 8,
    parameter int LANES       = 4,
    parameter int FRAME_BEATS = 64,
    parameter int LEAK_SHIFT  = 3
) (
    input logic         clk,
    input logic         rst,
    act_stream_if.slave bus
);
    localparam int DATA_W = LANES * BIT_REP;
    localparam int STAT_W = $clog2(FRAME_BEATS * LANES + 1);
    localparam int CNT_W  = $clog2(FRAME_BEATS);
    localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(FRAME_BEATS - 1);
    localparam logic signed [BIT_REP-1:0] ZERO      = '0;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_RELU  = 2'd1,
        MODE_LEAKY = 2'd2,
        MODE_CLAMP = 2'd3
    } act_mode_e;

    function automatic logic [BIT_REP-1:0] activate(
        input logic signed [BIT_REP-1:0] x,
        input act_mode_e                 md,
        input logic signed [BIT_REP-1:0] cmax
    );
        logic signed [BIT_REP-1:0] y;
        y = x;
        case (md)
            MODE_PASS:  y = x;
            MODE_RELU:  y = (x > ZERO) ? x : ZERO;
            MODE_LEAKY: y = x[BIT_REP-1] ? (x >>> LEAK_SHIFT) : x;
            MODE_CLAMP: begin
                if (cmax <= ZERO || x <= ZERO) y = ZERO;
                else if (x > cmax)             y = cmax;
                else                           y = x;
            end
        endcase
        return y;
    endfunction

    logic                      stall;
    logic                      in_hs;
    logic                      frame_start;

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    act_mode_e                 mode_lat_q, mode_lat_d;
    logic [BIT_REP-1:0]        clamp_lat_q, clamp_lat_d;

    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_last_q, s1_last_d;
    logic [DATA_W-1:0]         s1_data_q, s1_data_d;
    act_mode_e                 s1_mode_q, s1_mode_d;
    logic [BIT_REP-1:0]        s1_clamp_q, s1_clamp_d;

    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign in_hs        = bus.in_valid & ~stall;
    assign frame_start  = (cnt_q == '0);
    assign bus.in_ready = ~stall;

    // NOTE: every _d gets a hold default before any branch; a missed path would infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        mode_lat_d  = mode_lat_q;
        clamp_lat_d = clamp_lat_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        s1_clamp_d  = s1_clamp_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (in_hs) begin
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
            if (frame_start) begin
                mode_lat_d  = act_mode_e'(bus.mode);
                clamp_lat_d = bus.clamp_max;
            end
        end

        if (!stall) begin
            s1_valid_d  = bus.in_valid;
            s1_last_d   = (cnt_q == LAST_BEAT);
            s1_data_d   = bus.in_data;
            // Beat 0 runs with the live controls; the rest of the frame uses the latched copy.
            s1_mode_d   = frame_start ? act_mode_e'(bus.mode) : mode_lat_q;
            s1_clamp_d  = frame_start ? bus.clamp_max : clamp_lat_q;
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    out_data_d[i*BIT_REP +: BIT_REP] =
                        activate(s1_data_q[i*BIT_REP +: BIT_REP], s1_mode_q, s1_clamp_q);
                end
            end
        end
    end

    // NOTE: state registers take <= only; the blocking = stays in the combinational block above.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_lat_q  <= MODE_PASS;
            clamp_lat_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mode_lat_q  <= mode_lat_d;
            clamp_lat_q <= clamp_lat_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: S1 payload needs no reset; s1_valid_q masks it until a real beat lands.
    always_ff @(posedge clk) begin
        s1_data_q  <= s1_data_d;
        s1_mode_q  <= s1_mode_d;
        s1_clamp_q <= s1_clamp_d;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

`ifdef ACT_STATS_EN
    logic [STAT_W-1:0] acc_q, acc_d;
    logic [STAT_W-1:0] stat_zero_q, stat_zero_d;
    logic              stat_valid_q, stat_valid_d;
    logic [STAT_W-1:0] beat_zeros;

    always_comb begin
        beat_zeros = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_data_q[i*BIT_REP +: BIT_REP] == '0) beat_zeros = beat_zeros + 1'b1;
        end
        acc_d        = acc_q;
        stat_zero_d  = stat_zero_q;
        stat_valid_d = 1'b0;
        if (out_valid_q && bus.out_ready) begin
            if (out_last_q) begin
                stat_zero_d  = acc_q + beat_zeros;
                stat_valid_d = 1'b1;
                acc_d        = '0;
            end else begin
                acc_d = acc_q + beat_zeros;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            stat_zero_q  <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            stat_zero_q  <= stat_zero_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign bus.stat_zero  = stat_zero_q;
    assign bus.stat_valid = stat_valid_q;
`else
    assign bus.stat_zero  = '0;
    assign bus.stat_valid = 1'b0;
`endif

endmodule
